// File: rtl/neuron_mac_if.sv
// Handshake and result bundle between the activation source, neuron_mac and the threshold comparator.
// master drives start and the input pairs; slave (neuron_mac) returns ready, busy and the result.
interface neuron_mac_if #(
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACC_WIDTH    = 22
);
   logic                    start;
   logic                    in_valid;
   logic                    in_ready;
   logic [DATA_WIDTH-1:0]   in_data;
   logic [WEIGHT_WIDTH-1:0] in_weight;
   logic                    busy;
   logic [ACC_WIDTH-1:0]    mac_output;
   logic                    mac_valid;
   logic                    mac_sat;

   modport master (
      output start, in_valid, in_data, in_weight,
      input  in_ready, busy, mac_output, mac_valid, mac_sat
   );

   modport slave (
      input  start, in_valid, in_data, in_weight,
      output in_ready, busy, mac_output, mac_valid, mac_sat
   );
endinterface

// File: rtl/neuron_mac.sv
// Serial unsigned MAC: one data/weight pair per cycle, N_INPUTS products summed, result held for the comparator.
// Latency: last handshake -> mac_valid two edges later. MAC_SATURATE_EN selects clamping instead of wrapping.
module neuron_mac #(
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACC_WIDTH    = 22,
   parameter int N_INPUTS     = 64
) (
   input logic          clk,
   input logic          rst_n,
   neuron_mac_if.slave  bus
);
   localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
   localparam int CW = $clog2(N_INPUTS + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic [CW-1:0] N_CNT  = CW'(N_INPUTS);
   localparam logic [CW-1:0] N_LAST = CW'(N_INPUTS - 1);

   logic [1:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [PW-1:0]        prod_q, prod_d;
   logic                 prod_vld_q, prod_vld_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] out_q, out_d;
   logic                 out_vld_q, out_vld_d;
   logic [ACC_WIDTH-1:0] acc_add;
   logic                 in_ready;
   logic                 handshake;

   assign in_ready  = (state_q == ACCUM) && (cnt_q < N_CNT);
   assign handshake = bus.in_valid && in_ready;

`ifdef MAC_SATURATE_EN
   logic                 sat_q, sat_d;
   logic                 out_sat_q, out_sat_d;
   logic [ACC_WIDTH:0]   sum_w;
   logic                 ovf;

   // Once clamped, the run stays clamped even if later products are zero.
   always_comb begin
      sum_w = {1'b0, acc_q} + (ACC_WIDTH + 1)'(prod_q);
      ovf   = sat_q || sum_w[ACC_WIDTH];
      acc_add = ovf ? {ACC_WIDTH{1'b1}} : sum_w[ACC_WIDTH-1:0];
   end
`else
   always_comb begin
      acc_add = acc_q + ACC_WIDTH'(prod_q);
   end
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      prod_d     = prod_q;
      prod_vld_d = 1'b0;
      acc_d      = acc_q;
      out_d      = out_q;
      out_vld_d  = 1'b0;
`ifdef MAC_SATURATE_EN
      sat_d      = sat_q;
      out_sat_d  = out_sat_q;
      if (prod_vld_q) sat_d = ovf;
`endif
      if (prod_vld_q) acc_d = acc_add;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ACCUM;
`ifdef MAC_SATURATE_EN
               sat_d   = 1'b0;
`endif
            end
         end
         ACCUM: begin
            if (handshake) begin
               prod_d     = PW'(bus.in_data) * PW'(bus.in_weight);
               prod_vld_d = 1'b1;
               cnt_d      = cnt_q + 1'b1;
               if (cnt_q == N_LAST) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Publish only once the final product has landed in the accumulator.
            if (!prod_vld_q) begin
               out_d     = acc_q;
               out_vld_d = 1'b1;
               state_d   = IDLE;
`ifdef MAC_SATURATE_EN
               out_sat_d = sat_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
         acc_q      <= '0;
         out_q      <= '0;
         out_vld_q  <= 1'b0;
`ifdef MAC_SATURATE_EN
         sat_q      <= 1'b0;
         out_sat_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prod_q     <= prod_d;
         prod_vld_q <= prod_vld_d;
         acc_q      <= acc_d;
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
`ifdef MAC_SATURATE_EN
         sat_q      <= sat_d;
         out_sat_q  <= out_sat_d;
`endif
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.busy       = (state_q != IDLE);
   assign bus.mac_output = out_q;
   assign bus.mac_valid  = out_vld_q;
`ifdef MAC_SATURATE_EN
   assign bus.mac_sat    = out_sat_q;
`else
   assign bus.mac_sat    = 1'b0;
`endif
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: 64-input instance for the main runs, 70-input instance for overflow.
// Expected sums are hand-computed constants; overflow expectation follows MAC_SATURATE_EN.
module tb_neuron_mac;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   neuron_mac_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(22)) bus ();
   neuron_mac_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(22)) bus70 ();

   neuron_mac #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(22), .N_INPUTS(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   neuron_mac #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(22), .N_INPUTS(70)) dut70 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus70)
   );

`ifdef MAC_SATURATE_EN
   localparam logic [31:0] EXP70     = 32'd4194303;
   localparam logic [31:0] EXP70_SAT = 32'd1;
`else
   localparam logic [31:0] EXP70     = 32'd357446;
   localparam logic [31:0] EXP70_SAT = 32'd0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Returns with the last handshake edge just behind us (edge + 1).
   task automatic feed(input int n, input logic [7:0] d, input logic [7:0] w, input bit gaps,
                       output int hs, output int cyc);
      logic v;
      logic took;
      hs  = 0;
      cyc = 0;
      @(posedge clk); #1;
      while (hs < n && cyc < 4000) begin
         v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         bus.in_valid  = v;
         bus.in_data   = d;
         bus.in_weight = w;
         @(negedge clk);
         took = v && bus.in_ready;
         @(posedge clk); #1;
         if (took) hs++;
         cyc++;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic expect_result(input string tag, input logic [31:0] exp);
      bus.in_valid = 1'b1;
      @(negedge clk);
      check({tag, "_ready_after_last"}, 32'(bus.in_ready), 0);
      check({tag, "_valid_e1"}, 32'(bus.mac_valid), 0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_valid_e2"}, 32'(bus.mac_valid), 0);
      @(negedge clk);
      check({tag, "_valid_pulse"}, 32'(bus.mac_valid), 1);
      check({tag, "_output"}, 32'(bus.mac_output), exp);
      check({tag, "_sat"}, 32'(bus.mac_sat), 0);
      check({tag, "_busy_clear"}, 32'(bus.busy), 0);
      @(negedge clk);
      check({tag, "_valid_one_cycle"}, 32'(bus.mac_valid), 0);
      check({tag, "_output_held"}, 32'(bus.mac_output), exp);
   endtask

   initial begin
      int hs;
      int cyc;
      int waited;
      logic took;

      rst_n = 1'b0;
      bus.start = 1'b0;   bus.in_valid = 1'b0;   bus.in_data = '0;   bus.in_weight = '0;
      bus70.start = 1'b0; bus70.in_valid = 1'b0; bus70.in_data = '0; bus70.in_weight = '0;
      #1;
      check("rst_output", 32'(bus.mac_output), 0);
      check("rst_valid", 32'(bus.mac_valid), 0);
      check("rst_sat", 32'(bus.mac_sat), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_ready", 32'(bus.in_ready), 0);
      #20 rst_n = 1'b1;

      // 64 x (1*1), back-to-back
      pulse_start();
      @(negedge clk);
      check("t2_busy", 32'(bus.busy), 1);
      check("t2_ready", 32'(bus.in_ready), 1);
      feed(64, 8'd1, 8'd1, 1'b0, hs, cyc);
      check("t2_handshakes", 32'(hs), 64);
      check("t2_cycles", 32'(cyc), 64);
      expect_result("t2", 32'd64);

      // 64 x (255*255) with random valid gaps
      pulse_start();
      feed(64, 8'd255, 8'd255, 1'b1, hs, cyc);
      check("t3_handshakes", 32'(hs), 64);
      expect_result("t3", 32'd4161600);

      // start during ACCUM is ignored; run completes with all 64 beats of 2*3
      pulse_start();
      feed(20, 8'd2, 8'd3, 1'b0, hs, cyc);
      check("t4_first_part", 32'(hs), 20);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("t4_busy_kept", 32'(bus.busy), 1);
      check("t4_prev_held", 32'(bus.mac_output), 32'd4161600);
      check("t4_ready_kept", 32'(bus.in_ready), 1);
      feed(44, 8'd2, 8'd3, 1'b0, hs, cyc);
      check("t4_second_part", 32'(hs), 44);
      expect_result("t4", 32'd384);

      // asynchronous reset mid-run, mid-cycle
      pulse_start();
      feed(10, 8'd1, 8'd1, 1'b0, hs, cyc);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_output", 32'(bus.mac_output), 0);
      check("t5_rst_busy", 32'(bus.busy), 0);
      check("t5_rst_ready", 32'(bus.in_ready), 0);
      check("t5_rst_valid", 32'(bus.mac_valid), 0);
      #6 rst_n = 1'b1;
      pulse_start();
      feed(64, 8'd1, 8'd1, 1'b0, hs, cyc);
      check("t5_handshakes", 32'(hs), 64);
      expect_result("t5", 32'd64);

      // 70 x (255*255) overflows 22 bits
      @(posedge clk); #1;
      bus70.start = 1'b1;
      @(posedge clk); #1;
      bus70.start = 1'b0;
      bus70.in_data = 8'd255;
      bus70.in_weight = 8'd255;
      hs = 0;
      cyc = 0;
      while (hs < 70 && cyc < 500) begin
         bus70.in_valid = 1'b1;
         @(negedge clk);
         took = bus70.in_ready;
         @(posedge clk); #1;
         if (took) hs++;
         cyc++;
      end
      bus70.in_valid = 1'b0;
      check("t6_handshakes", 32'(hs), 70);
      waited = 0;
      @(negedge clk);
      while (!bus70.mac_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("t6_valid_edge", 32'(waited), 2);
      check("t6_output", 32'(bus70.mac_output), EXP70);
      check("t6_sat", 32'(bus70.mac_sat), EXP70_SAT);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
